color_cmd_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 2-bit command input of the Color Mealy state machine (Blue/Red) among NUM_REQ requesters.
- Latches one requester's command, drives it onto the FSM input, and captures the FSM's combinational output as the response.
- Retries until the FSM answers or a timeout expires, then returns a tagged response through a valid/ready handshake.
- Sits between the requester fabric and the Color FSM instance.

---
 rtl/color_arb_pkg.sv | 16 +
 rtl/color_cmd_arbiter_if.sv | 29 ++
 rtl/color_cmd_arbiter_rr_picker.sv | 38 +++
 rtl/color_cmd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_color_cmd_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/color_arb_pkg.sv
// Shared types and constants for the Color FSM command arbiter.
// The Color FSM decodes only CMD_TO_BLUE and CMD_TO_RED; NOP_CMD matches no transition.
package color_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] NOP_CMD     = 2'h3;
    localparam logic [1:0] CMD_TO_BLUE = 2'h1;
    localparam logic [1:0] CMD_TO_RED  = 2'h0;

endpackage

// File: rtl/color_cmd_arbiter_if.sv
// Requester-side bundle of the Color command arbiter.
// The master modport is the requester fabric; the slave modport is the arbiter.
interface color_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
) ();

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] cmd;
    logic [NUM_REQ-1:0]   gnt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_timeout;
    logic                 busy;

    modport master (
        output req, cmd, rsp_ready,
        input  gnt, rsp_valid, rsp_data, rsp_id, rsp_timeout, busy
    );

    modport slave (
        input  req, cmd, rsp_ready,
        output gnt, rsp_valid, rsp_data, rsp_id, rsp_timeout, busy
    );

endinterface

// File: rtl/color_cmd_arbiter_rr_picker.sv
// Combinational round-robin select: the first requester after rr_ptr wins,
// wrapping with an explicit compare so non-power-of-two NUM_REQ works.
module color_cmd_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    logic [ID_W:0]   raw_s;
    logic [ID_W:0]   pos_s;
    logic [ID_W-1:0] sel_s;
    logic            hit_s;

    // Scan far-to-near so the candidate nearest rr_ptr is the last one kept.
    always_comb begin
        raw_s  = '0;
        pos_s  = '0;
        sel_s  = '0;
        hit_s  = 1'b0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            raw_s = {1'b0, rr_ptr} + (ID_W+1)'(k);
            pos_s = (raw_s >= (ID_W+1)'(NUM_REQ)) ? (raw_s - (ID_W+1)'(NUM_REQ)) : raw_s;
            sel_s = pos_s[ID_W-1:0];
            hit_s = req[sel_s];
            idx   = hit_s ? sel_s : idx;
            valid = valid | hit_s;
        end
        onehot = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/color_cmd_arbiter.sv
// Round-robin arbiter sharing the Color FSM command input among NUM_REQ requesters;
// drives the winner's command, retries until an answer or timeout, returns a tagged response.
module color_cmd_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter int         TIMEOUT = 8,
    parameter logic [1:0] NOP_CMD = 2'h3
) (
    input  logic               clk,
    input  logic               rst_n,
    color_cmd_arbiter_if.slave bus,
    output logic [1:0]         fsm_in,
    input  logic [1:0]         fsm_out
);

    import color_arb_pkg::*;

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(NUM_REQ - 1);

    arb_state_t         state_r, state_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [1:0]         fsm_in_r, fsm_in_nxt_s;
    logic               rsp_valid_r, rsp_valid_nxt_s;
    logic [1:0]         rsp_data_r, rsp_data_nxt_s;
    logic [ID_W-1:0]    rsp_id_r, rsp_id_nxt_s;
    logic               rsp_timeout_r, rsp_timeout_nxt_s;
    logic               busy_r;
    logic [ID_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
    logic [1:0]         cmd_r, cmd_nxt_s;

    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic               pick_valid_s;
    logic [1:0]         cmd_sel_s;
    logic               answer_s;

    color_cmd_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    assign cmd_sel_s = bus.cmd[{pick_idx_s, 1'b0} +: 2];
    assign answer_s  = (fsm_out != 2'b00);

    // Next-state and next-output decode; fsm_in defaults to NOP so only ISSUE/WAIT drive a command.
    always_comb begin
        state_nxt_s       = state_r;
        gnt_nxt_s         = '0;
        fsm_in_nxt_s      = NOP_CMD;
        rsp_valid_nxt_s   = rsp_valid_r;
        rsp_data_nxt_s    = rsp_data_r;
        rsp_id_nxt_s      = rsp_id_r;
        rsp_timeout_nxt_s = rsp_timeout_r;
        rr_ptr_nxt_s      = rr_ptr_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        cmd_nxt_s         = cmd_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s  = ISSUE;
                    gnt_nxt_s    = pick_onehot_s;
                    cmd_nxt_s    = cmd_sel_s;
                    rsp_id_nxt_s = pick_idx_s;
                    rr_ptr_nxt_s = pick_idx_s;
                    fsm_in_nxt_s = cmd_sel_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (answer_s) begin
                    state_nxt_s       = RESP;
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_data_nxt_s    = fsm_out;
                    rsp_timeout_nxt_s = 1'b0;
                end else begin
                    state_nxt_s    = WAIT;
                    wait_cnt_nxt_s = '0;
                    fsm_in_nxt_s   = cmd_r;
                end
            end
            WAIT: begin
                // An answer in the final cycle still wins over the timeout.
                if (answer_s) begin
                    state_nxt_s       = RESP;
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_data_nxt_s    = fsm_out;
                    rsp_timeout_nxt_s = 1'b0;
                end else if (wait_cnt_r == LAST_WAIT) begin
                    state_nxt_s       = RESP;
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_data_nxt_s    = 2'b00;
                    rsp_timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s    = WAIT;
                    fsm_in_nxt_s   = cmd_r;
                    wait_cnt_nxt_s = (wait_cnt_r == CNT_MAX) ? wait_cnt_r : (wait_cnt_r + CNT_W'(1));
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s     = IDLE;
                    rsp_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            gnt_r         <= '0;
            fsm_in_r      <= NOP_CMD;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 2'b00;
            rsp_id_r      <= '0;
            rsp_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
            rr_ptr_r      <= PTR_RST;
            wait_cnt_r    <= '0;
            cmd_r         <= NOP_CMD;
        end else begin
            state_r       <= state_nxt_s;
            gnt_r         <= gnt_nxt_s;
            fsm_in_r      <= fsm_in_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_data_r    <= rsp_data_nxt_s;
            rsp_id_r      <= rsp_id_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            busy_r        <= (state_nxt_s != IDLE);
            rr_ptr_r      <= rr_ptr_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            cmd_r         <= cmd_nxt_s;
        end
    end

    assign fsm_in          = fsm_in_r;
    assign bus.gnt         = gnt_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_id      = rsp_id_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_color_cmd_arbiter.sv
// Bench for color_cmd_arbiter: a programmable Color FSM responder plus a transaction-level
// model of arbitration order, response latency, data and timeout.
module tb_color_cmd_arbiter;

    localparam int         N   = 4;
    localparam int         TO  = 8;
    localparam logic [1:0] NOP = 2'h3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] fsm_in;
    logic [1:0] fsm_out;
    logic [1:0] ans_val;
    int         ans_delay;
    int         active_cnt;
    int         checks = 0;
    int         errors = 0;
    int         ptr;

    color_cmd_arbiter_if #(.NUM_REQ(N)) arb_if ();

    color_cmd_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TO),
        .NOP_CMD (NOP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (arb_if),
        .fsm_in  (fsm_in),
        .fsm_out (fsm_out)
    );

    always #5 clk = ~clk;

    // Responder: answers ans_val once a command has been held ans_delay cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              active_cnt <= 0;
        else if (fsm_in == NOP)  active_cnt <= 0;
        else                     active_cnt <= active_cnt + 1;
    end
    assign fsm_out = (fsm_in != NOP && active_cnt >= ans_delay) ? ans_val : 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [N-1:0] add_req, input int d, input logic [1:0] val,
                           input int bp, input bit keep);
        int         win;
        int         edges;
        int         n;
        bit         answered;
        logic [1:0] wcmd;
        logic [1:0] exp_data;
        arb_if.req = arb_if.req | add_req;
        ans_delay  = d;
        ans_val    = val;
        win = -1;
        for (int k = 1; k <= N; k++)
            if (win < 0 && arb_if.req[(ptr + k) % N]) win = (ptr + k) % N;
        wcmd = arb_if.cmd[2*win +: 2];
        tick();
        edges = 1;
        while (arb_if.gnt == '0 && edges < 4) begin
            tick();
            edges++;
        end
        chk("grant_latency", edges, 1);
        chk("gnt_onehot", arb_if.gnt, 32'(1) << win);
        chk("busy_issue", arb_if.busy, 1);
        chk("fsm_in_issue", fsm_in, wcmd);
        ptr = win;
        if (!keep) arb_if.req[win] = 1'b0;
        answered = (val != 2'b00) && (d <= TO);
        exp_data = answered ? val : 2'b00;
        n = 0;
        while (!arb_if.rsp_valid && n < TO + 4) begin
            tick();
            n++;
            if (!arb_if.rsp_valid) begin
                chk("fsm_in_wait", fsm_in, wcmd);
                chk("gnt_quiet_wait", arb_if.gnt, 0);
            end
        end
        chk("rsp_latency", n, answered ? d + 1 : TO + 1);
        chk("rsp_data", arb_if.rsp_data, exp_data);
        chk("rsp_id", arb_if.rsp_id, win);
        chk("rsp_timeout", arb_if.rsp_timeout, !answered);
        chk("fsm_in_resp", fsm_in, NOP);
        arb_if.rsp_ready = 1'b0;
        repeat (bp) begin
            tick();
            chk("bp_valid", arb_if.rsp_valid, 1);
            chk("bp_data", arb_if.rsp_data, exp_data);
            chk("bp_id", arb_if.rsp_id, win);
            chk("bp_timeout", arb_if.rsp_timeout, !answered);
            chk("bp_gnt", arb_if.gnt, 0);
        end
        arb_if.rsp_ready = 1'b1;
        tick();
        arb_if.rsp_ready = 1'b0;
        chk("post_hs_valid", arb_if.rsp_valid, 0);
        chk("post_hs_busy", arb_if.busy, 0);
        chk("post_hs_fsm_in", fsm_in, NOP);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_gnt"}, arb_if.gnt, 0);
        chk({pfx, "_fsm_in"}, fsm_in, NOP);
        chk({pfx, "_rsp_valid"}, arb_if.rsp_valid, 0);
        chk({pfx, "_rsp_data"}, arb_if.rsp_data, 0);
        chk({pfx, "_rsp_id"}, arb_if.rsp_id, 0);
        chk({pfx, "_rsp_timeout"}, arb_if.rsp_timeout, 0);
        chk({pfx, "_busy"}, arb_if.busy, 0);
    endtask

    initial begin
        logic [N-1:0] add;
        rst_n            = 1'b0;
        arb_if.req       = '0;
        arb_if.cmd       = '0;
        arb_if.rsp_ready = 1'b0;
        ans_val          = 2'b00;
        ans_delay        = 0;
        ptr              = N - 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_no_req_busy", arb_if.busy, 0);
        chk("idle_no_req_gnt", arb_if.gnt, 0);

        // Round-robin with all four requesters held: order 0,1,2,3,0.
        arb_if.cmd = 8'b10_01_00_10;
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 2'h1, 0, 1'b1);
        arb_if.req = '0;

        // Single requester 2 with a to-Blue command answered in ISSUE.
        arb_if.cmd = 8'b00_01_00_00;
        run_txn(4'b0100, 0, 2'h1, 0, 1'b0);
        // No answer at all: timeout after TO wait cycles.
        run_txn(4'b0010, 0, 2'h0, 0, 1'b0);
        // Answer in the final wait cycle beats the timeout.
        run_txn(4'b1000, TO, 2'h2, 0, 1'b0);
        // Late answer during WAIT.
        run_txn(4'b0001, 4, 2'h2, 0, 1'b0);
        // Backpressure with other requests pending, then drain them.
        run_txn(4'b0111, 1, 2'h1, 5, 1'b0);
        run_txn(4'b0000, 2, 2'h3, 2, 1'b0);
        run_txn(4'b0000, TO + 1, 2'h1, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            for (int s = 0; s < N; s++) arb_if.cmd[2*s +: 2] = 2'($urandom_range(0, 2));
            add = N'($urandom_range(0, 15));
            if ((arb_if.req | add) == '0) add = N'(1) << $urandom_range(0, N - 1);
            run_txn(add, $urandom_range(0, TO + 2), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        arb_if.req = '0;
        tick();

        // Reset in the middle of WAIT: transaction dropped, pointer restarts.
        ans_val    = 2'b00;
        ans_delay  = 0;
        arb_if.req = 4'b0010;
        repeat (4) tick();
        chk("pre_reset_busy", arb_if.busy, 1);
        #2;
        rst_n      = 1'b0;
        arb_if.req = '0;
        #1;
        chk_reset_vals("async_reset");
        ptr = N - 1;
        tick();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_rsp_after_reset", arb_if.rsp_valid, 0);
            chk("idle_after_reset", arb_if.busy, 0);
        end
        run_txn(4'b1111, 0, 2'h1, 0, 1'b0);
        arb_if.req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
